// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the shared multi-cycle MULT/DIV units and commits HI/LO
module muldiv_sequencer #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             op_valid,
  input  logic             op_kind,
  input  logic             divisor_zero,
  input  logic             abort,
  input  logic             mult_done,
  input  logic             div_done,
  output logic             mult_start,
  output logic             div_start,
  output logic             busy,
  output logic             hi_write,
  output logic             lo_write,
  output logic             mux_high,
  output logic             mux_low,
  output logic             op_done,
  output logic             div_zero_exc,
  output logic             timeout_exc,
  output logic [2:0]       current_state,
  output logic [CNT_W-1:0] counter
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    M_START = 3'd1,
    M_WAIT  = 3'd2,
    D_START = 3'd3,
    D_WAIT  = 3'd4,
    WB      = 3'd5,
    DZ      = 3'd6,
    TO      = 3'd7
  } state_t;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_counter, w_counter_next;
  logic             r_sel, w_sel_next;
  // state, wait counter and result-source select registers
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      r_state   <= IDLE;
      r_counter <= '0;
      r_sel     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_counter <= w_counter_next;
      r_sel     <= w_sel_next;
    end
  end
  // next-state logic; abort overrides everything, done beats timeout
  always_comb begin
    w_next         = r_state;
    w_counter_next = r_counter;
    w_sel_next     = r_sel;
    if (abort) begin
      w_next         = IDLE;
      w_counter_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (op_valid && !op_kind) begin
            w_next     = M_START;
            w_sel_next = 1'b0;
          end else if (op_valid && divisor_zero) begin
            w_next = DZ;
          end else if (op_valid) begin
            w_next     = D_START;
            w_sel_next = 1'b1;
          end
        end
        M_START: begin
          w_next         = M_WAIT;
          w_counter_next = '0;
        end
        D_START: begin
          w_next         = D_WAIT;
          w_counter_next = '0;
        end
        M_WAIT: begin
          w_next         = mult_done ? WB : (r_counter == LP_LAST) ? TO : M_WAIT;
          w_counter_next = (mult_done || r_counter == LP_LAST) ? r_counter : r_counter + CNT_W'(1);
        end
        D_WAIT: begin
          w_next         = div_done ? WB : (r_counter == LP_LAST) ? TO : D_WAIT;
          w_counter_next = (div_done || r_counter == LP_LAST) ? r_counter : r_counter + CNT_W'(1);
        end
        default: w_next = IDLE;
      endcase
    end
  end
  assign mult_start    = (r_state == M_START);
  assign div_start     = (r_state == D_START);
  assign busy          = (r_state != IDLE);
  assign hi_write      = (r_state == WB);
  assign lo_write      = (r_state == WB);
  assign op_done       = (r_state == WB);
  assign div_zero_exc  = (r_state == DZ);
  assign timeout_exc   = (r_state == TO);
  assign mux_high      = r_sel;
  assign mux_low       = r_sel;
  assign current_state = r_state;
  assign counter       = r_counter;
endmodule
